ofm_drain: RTL and testbench

Read-side engine for the packed output feature-map buffer. On a start pulse it reads a contiguous range of 64-bit words from the output BRAM read port and unpacks each word into four 16-bit partial sums. The partial sums leave on a valid/ready stream toward host readout or the next layer's loader. It is the consumer counterpart of the accumulator/data_pack write path and owns the BRAM B-port address and enable while active.

---
 rtl/ofm_drain.sv | 140 ++++++++++++++
 tb/tb_ofm_drain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain.sv
// Read-side drain for the packed output feature-map BRAM: fetches a contiguous
// run of 64-bit words and streams each one out as four 16-bit partial sums, MSB lane first.
module ofm_drain #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int LANES  = DATA_W / LANE_W;
    localparam int LANE_B = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_B-1:0] LAST_LANE = LANE_B'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        STRM,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] word_q;
    logic [LANE_B-1:0] lane;
    logic [LANE_B-1:0] lane_nxt;
    logic              final_word;
    logic              handshake;

    // Lane 0 is the most significant slice, matching the packer's write order.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [DATA_W-1:0] w,
                                                   input logic [LANE_B-1:0] idx);
        return w[(LANES - 1 - int'(idx)) * LANE_W +: LANE_W];
    endfunction

    assign lane_nxt   = lane + LANE_B'(1);
    assign final_word = (remaining == ADDR_W'(1));
    assign handshake  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            word_q    <= '0;
            lane      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        if (word_count == '0) begin
                            state <= FIN;
                        end else begin
                            state    <= RD;
                            ram_en   <= 1'b1;
                            ram_addr <= base_addr;
                        end
                    end
                end

                RD: begin
                    ram_en <= 1'b0;
                    state  <= CAP;
                end

                CAP: begin
                    word_q    <= ram_dout;
                    lane      <= '0;
                    out_valid <= 1'b1;
                    out_data  <= lane_sel(ram_dout, '0);
                    out_last  <= (LAST_LANE == '0) && final_word;
                    state     <= STRM;
                end

                STRM: begin
                    if (handshake) begin
                        if (lane != LAST_LANE) begin
                            lane     <= lane_nxt;
                            out_data <= lane_sel(word_q, lane_nxt);
                            out_last <= (lane_nxt == LAST_LANE) && final_word;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            remaining <= remaining - ADDR_W'(1);
                            addr_q    <= addr_q + ADDR_W'(1);
                            if (final_word) begin
                                state <= FIN;
                            end else begin
                                state    <= RD;
                                ram_en   <= 1'b1;
                                ram_addr <= addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end

                // FIN spans two cycles: a settle cycle, then the done pulse with busy still high.
                FIN: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_drain.sv
// Randomized bench for ofm_drain: a queue-based model of the expected reads and lanes
// is checked every cycle, with literal expectations pinning the basic drain scenarios.
module tb_ofm_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic [63:0] ram_dout;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    ofm_drain #(.ADDR_W(16), .DATA_W(64), .LANE_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:65535];

    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic [15:0] data;
        logic        last;
    } lane_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    lane_t       exp_lanes[$];
    logic [15:0] exp_reads[$];
    logic [15:0] obs_data[$];
    int          obs_reads;
    bit          active = 0;
    int          start_cyc = 0;
    int          done_due = -1;
    int          done_seen_cyc = -1;
    bit          prev_stall = 0;
    logic [15:0] prev_data;
    logic        prev_last;
    int          ready_mode = 0;
    int          ready_cnt = 0;
    logic        ready_pat [4];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // A drain of N words from base reads base..base+N-1 (mod 2^16), four lanes each, MSB first.
    task automatic modelStart(input logic [15:0] base, input logic [15:0] count);
        logic [15:0] a;
        logic [63:0] w;
        lane_t       l;
        for (int i = 0; i < int'(count); i++) begin
            a = base + 16'(i);
            exp_reads.push_back(a);
            w = mem[a];
            for (int k = 0; k < 4; k++) begin
                l.data = 16'((w >> (48 - 16 * k)) & 64'hFFFF);
                l.last = (i == int'(count) - 1) && (k == 3);
                exp_lanes.push_back(l);
            end
        end
        active    = 1;
        start_cyc = cyc;
        done_due  = (count == 0) ? cyc + 2 : -1;
    endtask

    task automatic flushModel();
        active = 0;
        exp_lanes.delete();
        exp_reads.delete();
        done_due = -1;
    endtask

    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] count);
        @(posedge clk);
        #2;
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        if (!active) modelStart(base, count);
        @(posedge clk);
        #2;
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = $urandom;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (active && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (active) begin
            checkOutput("drain_timeout", 0, 1);
            flushModel();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_ram_en"}, ram_en, 0);
        checkOutput({tag, "_ram_addr"}, ram_addr, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
    endtask

    task automatic checkSequence(input string tag, input int first, input int n);
        checkOutput({tag, "_count"}, obs_data.size(), n);
        for (int i = 0; i < n && i < obs_data.size(); i++)
            checkOutput({tag, "_value"}, obs_data[i], 64'(first + i));
    endtask

    always @(posedge clk) begin
        #2;
        ready_cnt++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ready_pat[ready_cnt % 4];
            default: out_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    initial begin
        lane_t e;
        forever begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (active && cyc > start_cyc) checkOutput("busy_high", busy, 1);
                else if (!active) checkOutput("busy_low", busy, 0);
                if (!active) checkOutput("valid_idle", out_valid, 0);
                if (ram_en) begin
                    if (exp_reads.size() == 0) checkOutput("unexpected_read", ram_addr, 64'hDEAD);
                    else begin
                        checkOutput("read_addr", ram_addr, exp_reads.pop_front());
                        obs_reads++;
                    end
                end
                if (prev_stall) begin
                    checkOutput("stall_valid", out_valid, 1);
                    checkOutput("stall_data", out_data, prev_data);
                    checkOutput("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    obs_data.push_back(out_data);
                    if (exp_lanes.size() == 0) checkOutput("unexpected_lane", out_data, 64'hDEAD);
                    else begin
                        e = exp_lanes.pop_front();
                        checkOutput("lane_data", out_data, e.data);
                        checkOutput("lane_last", out_last, e.last);
                        if (exp_lanes.size() == 0) done_due = cyc + 2;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (done) begin
                    checkOutput("done_cycle", cyc, active ? done_due : -1);
                    done_seen_cyc = cyc;
                    active = 0;
                end else if (active && done_due >= 0 && cyc >= done_due) begin
                    checkOutput("done_missing", done, 1);
                    active = 0;
                end
            end
        end
    end

    initial begin
        int s;
        ready_pat[0] = 1'b1;
        ready_pat[1] = 1'b0;
        ready_pat[2] = 1'b0;
        ready_pat[3] = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom};
        mem[16'h0010] = 64'h0001_0002_0003_0004;
        mem[16'h0011] = 64'h0005_0006_0007_0008;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b1;
        #1;
        checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] basic drain");
        obs_data.delete();
        obs_reads = 0;
        applyStimulus(16'h0010, 16'd2);
        s = start_cyc;
        waitIdle(200);
        checkSequence("basic", 1, 8);
        checkOutput("basic_done_latency", done_seen_cyc - s, 14);
        checkOutput("basic_reads", obs_reads, 2);

        $display("[TB] backpressure");
        ready_mode = 1;
        obs_data.delete();
        applyStimulus(16'h0010, 16'd2);
        waitIdle(400);
        checkSequence("backpressure", 1, 8);
        ready_mode = 0;

        $display("[TB] zero count");
        obs_data.delete();
        obs_reads = 0;
        applyStimulus(16'h0030, 16'd0);
        s = start_cyc;
        waitIdle(50);
        checkOutput("zero_done_latency", done_seen_cyc - s, 2);
        checkOutput("zero_reads", obs_reads, 0);
        checkOutput("zero_lanes", obs_data.size(), 0);

        $display("[TB] wrap-around");
        obs_reads = 0;
        applyStimulus(16'hFFFF, 16'd2);
        waitIdle(200);
        checkOutput("wrap_reads", obs_reads, 2);

        $display("[TB] start while busy");
        obs_data.delete();
        applyStimulus(16'h0010, 16'd2);
        repeat (4) @(posedge clk);
        applyStimulus(16'h0200, 16'd3);
        waitIdle(200);
        checkSequence("busy_start", 1, 8);

        $display("[TB] reset mid-drain");
        applyStimulus(16'h0010, 16'd2);
        s = start_cyc;
        while (cyc < s + 11) @(negedge clk);
        #1;
        checkOutput("pre_reset_lane", out_data, 16'h0007);
        rst_n = 1'b0;
        flushModel();
        #1;
        checkResetOutputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        obs_data.delete();
        applyStimulus(16'h0010, 16'd1);
        waitIdle(100);
        checkSequence("after_reset", 1, 4);

        $display("[TB] randomized drains");
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            applyStimulus(16'($urandom), 16'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                applyStimulus(16'($urandom), 16'($urandom_range(0, 4)));
            end
            waitIdle(400);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        ready_mode = 0;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
